atm_session_ctrl: RTL and testbench
===================================

ATM_SESSION_CTRL -- requirements
Module: atm_session_ctrl

Interface
REQ-001 Parameter balance_width, default 20, width of balance, amount and updated_balance.
REQ-002 Parameter max_tries, default 3, wrong-password attempts before card retention (range 1..7).
REQ-003 Parameter timeout_cycles, default 1000, inactivity limit in clk cycles (used only with ATM_TIMEOUT_EN).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 card_in  in  1  card inserted and read; level.
REQ-007 card_out  in  1  user eject request; pulse.
REQ-008 psw_submit  in  1  password entry complete, sent to cardhandling this cycle; pulse.
REQ-009 wrong_psw  in  1  cardhandling verdict, valid the cycle after psw_submit.
REQ-010 balance  in  balance_width  current account balance from cardhandling.
REQ-011 op_start  in  1  start transaction; pulse.
REQ-012 op_sel  in  2  00 none, 01 withdraw, 10 deposit, 11 inquiry.
REQ-013 amount  in  balance_width  transaction amount.
REQ-014 psw_en  out  1  password entry enabled.
REQ-015 op_done  out  1  one-cycle write strobe to cardhandling.
REQ-016 updated_balance  out  balance_width  new balance, valid while op_done=1.
REQ-017 dispense  out  1  one-cycle cash-dispense strobe.
REQ-018 op_err  out  1  one-cycle reject strobe (insufficient funds/overflow/op_sel=00).
REQ-019 card_eject  out  1  one-cycle eject strobe.
REQ-020 card_retain  out  1  one-cycle retain strobe.
REQ-021 tries  out  3  wrong-password count this session.

Function
REQ-022 States SHALL be IDLE, AUTH, CHECK, MENU, COMMIT, EJECT, RETAIN; all outputs registered.
REQ-023 IDLE: card_in=1 -> AUTH, tries cleared; otherwise hold.
REQ-024 AUTH: psw_en=1; psw_submit=1 -> CHECK; card_out=1 (without psw_submit) -> EJECT.
REQ-025 CHECK: wrong_psw=0 -> MENU; wrong_psw=1 -> tries+1, then RETAIN if tries+1==max_tries else AUTH; card_out ignored in CHECK.
REQ-026 MENU: op_start with card_out same cycle -> op_start wins, card_out dropped.
REQ-027 Withdraw: amount<=balance -> COMMIT with updated_balance=balance-amount, dispense=1 same cycle as op_done; amount>balance -> op_err=1, stay MENU.
REQ-028 Deposit: balance+amount computed at balance_width+1 bits; carry=0 -> COMMIT with updated_balance=sum; carry=1 -> op_err=1, stay MENU.
REQ-029 Inquiry: no op_done, no op_err, stay MENU; op_sel=00 -> op_err=1.
REQ-030 COMMIT: op_done=1 exactly one cycle, then MENU; card_out during COMMIT is latched and causes MENU -> EJECT next cycle.
REQ-031 MENU: card_out=1 (no op_start) -> EJECT.
REQ-032 EJECT: card_eject=1 one cycle -> IDLE; RETAIN: card_retain=1 one cycle -> IDLE.
REQ-033 updated_balance SHALL hold its last value outside COMMIT; amount=0 withdraw/deposit is legal and commits.

Reset
REQ-034 rst=1 SHALL force IDLE, tries=0, updated_balance=0, all strobes and psw_en to 0 on the next edge, in any state, aborting any transaction (no op_done emitted).
REQ-035 rst SHALL have priority over all other inputs.

Configuration
REQ-036 With ATM_TIMEOUT_EN defined: counter clears on any of psw_submit, op_start, card_out or state change; counter reaching timeout_cycles in AUTH or MENU SHALL force EJECT; counter frozen in other states.
REQ-037 Without ATM_TIMEOUT_EN: no counter logic; AUTH and MENU wait indefinitely; timeout_cycles unused.

Verification
REQ-038 card_in=1, psw_submit, wrong_psw=0, op_sel=01, amount=300, balance=1000 -> op_done=1, dispense=1, updated_balance=700 for one cycle, back in MENU.
REQ-039 balance=100, withdraw amount=101 -> op_err=1 one cycle, no op_done, state MENU.
REQ-040 balance=20'hFFFF0, deposit amount=16'h20 -> op_err=1; amount=16'hF -> updated_balance=20'hFFFFF.
REQ-041 Three submits with wrong_psw=1 (max_tries=3) -> tries 1,2, then card_retain=1 one cycle, IDLE, tries=0 after next card_in.
REQ-042 rst=1 during COMMIT -> op_done=0 next cycle, all outputs 0, IDLE; card_out during COMMIT -> op_done, then MENU, then card_eject.
REQ-043 ATM_TIMEOUT_EN, timeout_cycles=8: MENU with no input 8 cycles -> card_eject=1, IDLE.

Source files
------------

// File: rtl/atm_session_ctrl_if.sv
// Session-controller bus: card/password/transaction inputs from the front panel
// and cardhandling, plus the registered strobes and status going back.
interface atm_session_ctrl_if #(
    parameter int balance_width = 20
);
    logic                     card_in;
    logic                     card_out;
    logic                     psw_submit;
    logic                     wrong_psw;
    logic [balance_width-1:0] balance;
    logic                     op_start;
    logic [1:0]               op_sel;
    logic [balance_width-1:0] amount;

    logic                     psw_en;
    logic                     op_done;
    logic [balance_width-1:0] updated_balance;
    logic                     dispense;
    logic                     op_err;
    logic                     card_eject;
    logic                     card_retain;
    logic [2:0]               tries;

    modport master (
        output card_in, card_out, psw_submit, wrong_psw, balance, op_start, op_sel, amount,
        input  psw_en, op_done, updated_balance, dispense, op_err, card_eject, card_retain, tries
    );

    modport slave (
        input  card_in, card_out, psw_submit, wrong_psw, balance, op_start, op_sel, amount,
        output psw_en, op_done, updated_balance, dispense, op_err, card_eject, card_retain, tries
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session FSM: authentication, withdraw/deposit/inquiry, eject/retain.
// Optional inactivity timeout in AUTH/MENU enabled by defining ATM_TIMEOUT_EN.
module atm_session_ctrl #(
    parameter int balance_width  = 20,
    parameter int max_tries      = 3,
    parameter int timeout_cycles = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_session_ctrl_if.slave    bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] AUTH   = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] MENU   = 3'd3;
    localparam logic [2:0] COMMIT = 3'd4;
    localparam logic [2:0] EJECT  = 3'd5;
    localparam logic [2:0] RETAIN = 3'd6;

    logic [2:0]               state_q, state_d;
    logic [2:0]               tries_q, tries_d, tries_inc;
    logic [balance_width-1:0] upd_q, upd_d;
    logic                     op_done_q, op_done_d;
    logic                     dispense_q, dispense_d;
    logic                     op_err_q, op_err_d;
    logic                     psw_en_q, eject_q, retain_q;
    logic                     pend_q, pend_d;
    logic [balance_width:0]   sum;
    logic                     to_hit;

`ifdef ATM_TIMEOUT_EN
    localparam int TW = (timeout_cycles > 1) ? $clog2(timeout_cycles) + 1 : 1;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          activity, waiting;

    assign activity = bus.psw_submit | bus.op_start | bus.card_out;
    assign waiting  = (state_q == AUTH) || (state_q == MENU);
    assign to_hit   = waiting && !activity && (to_cnt_q == TW'(timeout_cycles - 1));

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (activity || (state_d != state_q)) to_cnt_d = '0;
        else if (waiting)                     to_cnt_d = to_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) to_cnt_q <= '0;
        else     to_cnt_q <= to_cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    assign sum       = {1'b0, bus.balance} + {1'b0, bus.amount};
    assign tries_inc = tries_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        upd_d      = upd_q;
        op_done_d  = 1'b0;
        dispense_d = 1'b0;
        op_err_d   = 1'b0;
        pend_d     = pend_q;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (bus.card_in) begin
                    state_d = AUTH;
                    tries_d = 3'd0;
                end
            end
            AUTH: begin
                if (bus.psw_submit)    state_d = CHECK;
                else if (bus.card_out) state_d = EJECT;
            end
            CHECK: begin
                if (bus.wrong_psw) begin
                    tries_d = tries_inc;
                    state_d = (tries_inc == 3'(max_tries)) ? RETAIN : AUTH;
                end else begin
                    state_d = MENU;
                end
            end
            MENU: begin
                // An eject requested during COMMIT is honoured before any new op.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = EJECT;
                end else if (bus.op_start) begin
                    case (bus.op_sel)
                        2'b01: begin
                            if (bus.amount <= bus.balance) begin
                                state_d    = COMMIT;
                                upd_d      = bus.balance - bus.amount;
                                op_done_d  = 1'b1;
                                dispense_d = 1'b1;
                            end else begin
                                op_err_d = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (!sum[balance_width]) begin
                                state_d   = COMMIT;
                                upd_d     = sum[balance_width-1:0];
                                op_done_d = 1'b1;
                            end else begin
                                op_err_d = 1'b1;
                            end
                        end
                        2'b11:   ;
                        default: op_err_d = 1'b1;
                    endcase
                end else if (bus.card_out) begin
                    state_d = EJECT;
                end
            end
            COMMIT: begin
                state_d = MENU;
                if (bus.card_out) pend_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (to_hit) state_d = EJECT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tries_q    <= 3'd0;
            upd_q      <= '0;
            op_done_q  <= 1'b0;
            dispense_q <= 1'b0;
            op_err_q   <= 1'b0;
            psw_en_q   <= 1'b0;
            eject_q    <= 1'b0;
            retain_q   <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            upd_q      <= upd_d;
            op_done_q  <= op_done_d;
            dispense_q <= dispense_d;
            op_err_q   <= op_err_d;
            psw_en_q   <= (state_d == AUTH);
            eject_q    <= (state_d == EJECT);
            retain_q   <= (state_d == RETAIN);
            pend_q     <= pend_d;
        end
    end

    assign bus.psw_en          = psw_en_q;
    assign bus.op_done         = op_done_q;
    assign bus.updated_balance = upd_q;
    assign bus.dispense        = dispense_q;
    assign bus.op_err          = op_err_q;
    assign bus.card_eject      = eject_q;
    assign bus.card_retain     = retain_q;
    assign bus.tries           = tries_q;
endmodule

// File: tb/tb_atm_session_ctrl.sv
// Randomized self-checking bench for atm_session_ctrl against a transaction-level model.
module tb_atm_session_ctrl;
    localparam int BW   = 20;
    localparam int MAXT = 3;
    localparam int TO   = 8;
    localparam longint LIM = longint'(1) << BW;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    longint last_upd = 0;

    atm_session_ctrl_if #(.balance_width(BW)) bus ();

    atm_session_ctrl #(.balance_width(BW), .max_tries(MAXT), .timeout_cycles(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.card_in = 0; bus.card_out = 0; bus.psw_submit = 0; bus.wrong_psw = 0;
        bus.op_start = 0; bus.op_sel = 2'b00; bus.amount = '0; bus.balance = '0;
    endtask

    task automatic login();
        bus.card_in = 1; tick(); bus.card_in = 0;
        bus.psw_submit = 1; tick(); bus.psw_submit = 0;
        bus.wrong_psw = 0; tick();
    endtask

    task automatic leave();
        bus.card_out = 1; tick(); bus.card_out = 0; tick();
    endtask

    task automatic issue(input logic [1:0] sel, input longint bal, input longint amt);
        bus.op_sel = sel; bus.balance = BW'(bal); bus.amount = BW'(amt);
        bus.op_start = 1; tick(); bus.op_start = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs(); tick(); tick(); rst = 0;
        vectors++; if ({bus.psw_en, bus.op_done, bus.dispense, bus.op_err, bus.card_eject, bus.card_retain} !== 6'b0)
            begin miscompares++; $display("FAIL reset_strobes got=%b exp=000000", {bus.psw_en, bus.op_done, bus.dispense, bus.op_err, bus.card_eject, bus.card_retain}); end
        vectors++; if (bus.tries !== 3'd0 || bus.updated_balance !== '0)
            begin miscompares++; $display("FAIL reset_regs tries=%0d upd=%0h exp 0/0", bus.tries, bus.updated_balance); end
        last_upd = 0;
    endtask

    task automatic test_login();
        bus.card_in = 1; tick(); bus.card_in = 0;
        vectors++; if (bus.psw_en !== 1'b1) begin miscompares++; $display("FAIL auth_psw_en got=%b exp=1", bus.psw_en); end
        bus.psw_submit = 1; tick(); bus.psw_submit = 0;
        // card_out while the verdict is pending must be ignored
        bus.card_out = 1; bus.wrong_psw = 0; tick(); bus.card_out = 0;
        vectors++; if (bus.psw_en !== 1'b0 || bus.card_eject !== 1'b0)
            begin miscompares++; $display("FAIL check_ignores_out psw_en=%b eject=%b exp 0/0", bus.psw_en, bus.card_eject); end
        tick();
        vectors++; if (bus.card_eject !== 1'b0) begin miscompares++; $display("FAIL menu_stable eject=%b exp=0", bus.card_eject); end
    endtask

    task automatic test_withdraw();
        issue(2'b01, 1000, 300);
        vectors++; if (bus.op_done !== 1 || bus.dispense !== 1 || bus.updated_balance !== BW'(700))
            begin miscompares++; $display("FAIL withdraw done=%b disp=%b upd=%0d exp 1/1/700", bus.op_done, bus.dispense, bus.updated_balance); end
        tick();
        vectors++; if (bus.op_done !== 0 || bus.dispense !== 0 || bus.updated_balance !== BW'(700))
            begin miscompares++; $display("FAIL withdraw_after done=%b disp=%b upd=%0d exp 0/0/700", bus.op_done, bus.dispense, bus.updated_balance); end
        issue(2'b01, 100, 101);
        vectors++; if (bus.op_err !== 1 || bus.op_done !== 0)
            begin miscompares++; $display("FAIL insufficient err=%b done=%b exp 1/0", bus.op_err, bus.op_done); end
        tick();
        vectors++; if (bus.op_err !== 0 || bus.updated_balance !== BW'(700))
            begin miscompares++; $display("FAIL insufficient_after err=%b upd=%0d exp 0/700", bus.op_err, bus.updated_balance); end
        last_upd = 700;
    endtask

    task automatic test_deposit_edges();
        issue(2'b10, 'hFFFF0, 'h20);
        vectors++; if (bus.op_err !== 1 || bus.op_done !== 0)
            begin miscompares++; $display("FAIL deposit_ovf err=%b done=%b exp 1/0", bus.op_err, bus.op_done); end
        tick();
        issue(2'b10, 'hFFFF0, 'hF);
        vectors++; if (bus.op_done !== 1 || bus.dispense !== 0 || bus.updated_balance !== BW'('hFFFFF))
            begin miscompares++; $display("FAIL deposit_max done=%b disp=%b upd=%0h exp 1/0/fffff", bus.op_done, bus.dispense, bus.updated_balance); end
        tick();
        issue(2'b11, 5, 5);
        vectors++; if (bus.op_done !== 0 || bus.op_err !== 0 || bus.updated_balance !== BW'('hFFFFF))
            begin miscompares++; $display("FAIL inquiry done=%b err=%b upd=%0h exp 0/0/fffff", bus.op_done, bus.op_err, bus.updated_balance); end
        issue(2'b00, 5, 5);
        vectors++; if (bus.op_err !== 1 || bus.op_done !== 0)
            begin miscompares++; $display("FAIL op_none err=%b done=%b exp 1/0", bus.op_err, bus.op_done); end
        tick();
        last_upd = 'hFFFFF;
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 60; i++) begin
            longint b, a, s;
            bit exp_done, exp_disp, exp_err;
            logic [1:0] sel;
            sel = 2'($urandom_range(0, 3));
            b = longint'($urandom_range(0, 32'(LIM - 1)));
            case ($urandom_range(0, 4))
                0:       a = b;
                1:       a = (b + 1) % LIM;
                2:       a = 0;
                3:       a = LIM - 1 - b;
                default: a = longint'($urandom_range(0, 32'(LIM - 1)));
            endcase
            exp_done = 0; exp_disp = 0; exp_err = 0;
            case (sel)
                2'b01: if (a <= b) begin exp_done = 1; exp_disp = 1; last_upd = b - a; end else exp_err = 1;
                2'b10: begin s = a + b; if (s < LIM) begin exp_done = 1; last_upd = s; end else exp_err = 1; end
                2'b11: ;
                default: exp_err = 1;
            endcase
            issue(sel, b, a);
            vectors++; if (bus.op_done !== exp_done || bus.dispense !== exp_disp || bus.op_err !== exp_err || bus.updated_balance !== BW'(last_upd))
                begin miscompares++; $display("FAIL rand_op[%0d] sel=%0d b=%0h a=%0h got done=%b disp=%b err=%b upd=%0h exp %b/%b/%b/%0h",
                    i, sel, b, a, bus.op_done, bus.dispense, bus.op_err, bus.updated_balance, exp_done, exp_disp, exp_err, last_upd); end
            tick();
        end
    endtask

    task automatic test_commit_eject();
        issue(2'b01, 50, 0);
        last_upd = 50;
        bus.card_out = 1; tick(); bus.card_out = 0;
        vectors++; if (bus.op_done !== 0 || bus.card_eject !== 0)
            begin miscompares++; $display("FAIL commit_out_menu done=%b eject=%b exp 0/0", bus.op_done, bus.card_eject); end
        tick();
        vectors++; if (bus.card_eject !== 1 || bus.updated_balance !== BW'(last_upd))
            begin miscompares++; $display("FAIL commit_out_eject eject=%b upd=%0d exp 1/%0d", bus.card_eject, bus.updated_balance, last_upd); end
        tick();
        vectors++; if (bus.card_eject !== 0) begin miscompares++; $display("FAIL eject_pulse got=%b exp=0", bus.card_eject); end
    endtask

    task automatic test_start_beats_out();
        login();
        bus.card_out = 1; issue(2'b10, 10, 5); bus.card_out = 0;
        vectors++; if (bus.op_done !== 1 || bus.card_eject !== 0 || bus.updated_balance !== BW'(15))
            begin miscompares++; $display("FAIL start_wins done=%b eject=%b upd=%0d exp 1/0/15", bus.op_done, bus.card_eject, bus.updated_balance); end
        tick(); tick();
        vectors++; if (bus.card_eject !== 0) begin miscompares++; $display("FAIL out_dropped eject=%b exp=0", bus.card_eject); end
        last_upd = 15;
        leave();
    endtask

    task automatic test_wrong_psw();
        bus.card_in = 1; tick(); bus.card_in = 0;
        for (int n = 1; n <= MAXT; n++) begin
            bus.psw_submit = 1; tick(); bus.psw_submit = 0;
            bus.wrong_psw = 1; tick(); bus.wrong_psw = 0;
            if (n < MAXT) begin
                vectors++; if (bus.tries !== 3'(n) || bus.psw_en !== 1 || bus.card_retain !== 0)
                    begin miscompares++; $display("FAIL wrong_try[%0d] tries=%0d psw_en=%b retain=%b exp %0d/1/0", n, bus.tries, bus.psw_en, bus.card_retain, n); end
            end else begin
                vectors++; if (bus.card_retain !== 1 || bus.psw_en !== 0)
                    begin miscompares++; $display("FAIL retain retain=%b psw_en=%b exp 1/0", bus.card_retain, bus.psw_en); end
            end
        end
        tick();
        vectors++; if (bus.card_retain !== 0) begin miscompares++; $display("FAIL retain_pulse got=%b exp=0", bus.card_retain); end
        bus.card_in = 1; tick(); bus.card_in = 0;
        vectors++; if (bus.tries !== 3'd0 || bus.psw_en !== 1)
            begin miscompares++; $display("FAIL tries_clear tries=%0d psw_en=%b exp 0/1", bus.tries, bus.psw_en); end
        bus.card_out = 1; tick(); bus.card_out = 0;
        vectors++; if (bus.card_eject !== 1) begin miscompares++; $display("FAIL auth_eject got=%b exp=1", bus.card_eject); end
        tick();
    endtask

    task automatic test_reset_commit();
        login();
        issue(2'b01, 900, 1);
        rst = 1; tick(); rst = 0;
        vectors++; if ({bus.op_done, bus.dispense, bus.op_err, bus.psw_en, bus.card_eject, bus.card_retain} !== 6'b0 || bus.updated_balance !== '0 || bus.tries !== 3'd0)
            begin miscompares++; $display("FAIL reset_commit strobes=%b upd=%0d tries=%0d exp 0", {bus.op_done, bus.dispense, bus.op_err, bus.psw_en, bus.card_eject, bus.card_retain}, bus.updated_balance, bus.tries); end
        last_upd = 0;
        login();
        rst = 1; bus.op_start = 1; bus.op_sel = 2'b10; bus.balance = BW'(1); bus.amount = BW'(1); tick();
        rst = 0; bus.op_start = 0;
        vectors++; if (bus.op_done !== 0 || bus.updated_balance !== '0)
            begin miscompares++; $display("FAIL reset_priority done=%b upd=%0d exp 0/0", bus.op_done, bus.updated_balance); end
        tick();
        vectors++; if (bus.psw_en !== 0) begin miscompares++; $display("FAIL idle_hold psw_en=%b exp=0", bus.psw_en); end
    endtask

`ifdef ATM_TIMEOUT_EN
    task automatic test_timeout();
        login();
        repeat (TO - 1) tick();
        vectors++; if (bus.card_eject !== 0) begin miscompares++; $display("FAIL timeout_early eject=%b exp=0", bus.card_eject); end
        tick();
        vectors++; if (bus.card_eject !== 1) begin miscompares++; $display("FAIL timeout_eject eject=%b exp=1", bus.card_eject); end
        tick();
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_login();
        test_withdraw();
        test_deposit_edges();
        test_random_ops();
        test_commit_eject();
        test_start_beats_out();
        test_wrong_psw();
        test_reset_commit();
`ifdef ATM_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
